// File: rtl/bcd_pkg.sv
// Shared constants, state type and digit-validity helper for the BCD-to-binary converter.
package bcd_pkg;

  localparam int unsigned BCD_NDIG  = 8;
  localparam int unsigned BCD_WIDTH = 32;
  localparam int unsigned BCD_ITER  = 32;

  localparam logic [3:0] BCD_ADJ_THR = 4'd8;
  localparam logic [3:0] BCD_ADJ_OFF = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } bcd_state_e;

  function automatic logic bcd_has_invalid(input logic [BCD_WIDTH-1:0] v);
    logic bad;
    bad = 1'b0;
    for (int unsigned i = 0; i < BCD_NDIG; i++) begin
      if (v[4*i +: 4] > 4'd9) bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Per-digit correction for reverse double-dabble: subtract 3 from any digit >= 8.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= BCD_ADJ_THR) digit_o = digit_i - BCD_ADJ_OFF;
  end

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential 8-digit BCD to 32-bit binary converter, one bit per clock.
// Optional signed result via BCD2BIN_SIGN_EN (adds the negativo input).
module bcd_to_bin
  import bcd_pkg::*;
(
  input  logic        clock,
  input  logic        resetn,
  input  logic        start,
  input  logic [3:0]  dmilhao,
  input  logic [3:0]  milhao,
  input  logic [3:0]  cmilhar,
  input  logic [3:0]  dmilhar,
  input  logic [3:0]  milhar,
  input  logic [3:0]  centesimal,
  input  logic [3:0]  decimal,
  input  logic [3:0]  unidade,
`ifdef BCD2BIN_SIGN_EN
  input  logic        negativo,
`endif
  output logic [31:0] dataBin,
  output logic        busy,
  output logic        done,
  output logic        erro
);

  localparam logic [4:0] CNT_LAST = 5'(BCD_ITER - 1);

  bcd_state_e           state_q, state_d;
  logic [BCD_WIDTH-1:0] bcd_q, bcd_d;
  logic [BCD_WIDTH-1:0] acc_q, acc_d;
  logic [4:0]           cnt_q, cnt_d;
  logic [BCD_WIDTH-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 erro_q, erro_d;

  logic [BCD_WIDTH-1:0] digits;
  logic [BCD_WIDTH-1:0] bcd_shr;
  logic [BCD_WIDTH-1:0] bcd_adj;
  logic [BCD_WIDTH-1:0] acc_nxt;
  logic [BCD_WIDTH-1:0] result;

  assign digits  = {dmilhao, milhao, cmilhar, dmilhar, milhar, centesimal, decimal, unidade};
  assign bcd_shr = bcd_q >> 1;
  assign acc_nxt = {bcd_q[0], acc_q[BCD_WIDTH-1:1]};

  for (genvar g = 0; g < BCD_NDIG; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i (bcd_shr[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

`ifdef BCD2BIN_SIGN_EN
  logic neg_q, neg_d;
  // Negate on the final accumulator value so the sign costs no extra cycle.
  assign result = neg_q ? (~acc_nxt + 32'd1) : acc_nxt;
`else
  assign result = acc_nxt;
`endif

  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    done_d  = 1'b0;
    erro_d  = erro_q;
`ifdef BCD2BIN_SIGN_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (bcd_has_invalid(digits)) begin
            data_d = '0;
            erro_d = 1'b1;
            done_d = 1'b1;
          end else begin
            bcd_d   = digits;
            acc_d   = '0;
            cnt_d   = '0;
            erro_d  = 1'b0;
`ifdef BCD2BIN_SIGN_EN
            neg_d   = negativo;
`endif
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_nxt;
        bcd_d = bcd_adj;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == CNT_LAST) begin
          data_d  = result;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      erro_q  <= 1'b0;
`ifdef BCD2BIN_SIGN_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      done_q  <= done_d;
      erro_q  <= erro_d;
`ifdef BCD2BIN_SIGN_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign dataBin = data_q;
  assign busy    = (state_q == SHIFT);
  assign done    = done_q;
  assign erro    = erro_q;

endmodule
